// File: rtl/dac_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dac_ctrl_pkg
//  Purpose  : Shared types and default constants for the dac045a control
//             slice: FSM state encoding, default frame timing and the mode
//             encodings understood by the dac045a core.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package dac_ctrl_pkg;

  // Default frame timing: 11.905 MHz system clock / 300 Hz frame rate.
  localparam int DAC_CLK_DIV_300HZ = 39683;
  localparam int DAC_ARM_CYCLES    = 16;
  localparam int DAC_N_SAMPLES     = 256;

  // dac045a mode encodings.
  localparam logic DAC_MODE_FIXED = 1'b0;
  localparam logic DAC_MODE_WAVE  = 1'b1;

  // Frame scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } dac_state_e;

endpackage : dac_ctrl_pkg
`default_nettype wire

// File: rtl/dac_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : dac_frame_scheduler_if
//  Purpose  : Host-side control bundle for the frame scheduler: run enable,
//             requested mode and the fixed-value valid/ready handshake.
//  Ports    : enable    - run request level (host -> scheduler)
//             mode_req  - requested dac045a mode (host -> scheduler)
//             fv_valid  - fixed value offered (host -> scheduler)
//             fv_data   - fixed value payload, 16 bits (host -> scheduler)
//             fv_ready  - shadow register free (scheduler -> host)
//  Revision : 1.0  initial release
// ============================================================================
interface dac_frame_scheduler_if;

  logic        enable;
  logic        mode_req;
  logic        fv_valid;
  logic [15:0] fv_data;
  logic        fv_ready;

  // Host / register block side.
  modport master (
    output enable,
    output mode_req,
    output fv_valid,
    output fv_data,
    input  fv_ready
  );

  // Frame scheduler side.
  modport slave (
    input  enable,
    input  mode_req,
    input  fv_valid,
    input  fv_data,
    output fv_ready
  );

endinterface : dac_frame_scheduler_if
`default_nettype wire

// File: rtl/dac_tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : dac_tick_div
//  Purpose  : Free-running modulo-CLK_DIV counter for periodic strobes.
//             Counts 0..CLK_DIV-1 while run=1 and wraps; clear forces the
//             count back to 0 and has priority over run.
//  Ports    : clk    - system clock
//             rst_l  - synchronous active-low reset
//             clear  - force count to 0 on the next edge
//             run    - advance the count on the next edge
//             tick   - count is 0
//             wrap   - count is CLK_DIV-1 (next advance returns to 0)
//  Revision : 1.0  initial release
// ============================================================================
module dac_tick_div #(
  parameter int CLK_DIV = 39683
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clear,
  input  logic run,
  output logic tick,
  output logic wrap
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_l || clear) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= wrap ? '0 : (r_count + c_cnt_one);
    end
  end

  assign tick = (r_count == '0);
  assign wrap = (r_count == c_cnt_last);

endmodule : dac_tick_div
`default_nettype wire

// File: rtl/dac_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dac_frame_scheduler
//  Purpose  : Sequences the dac045a core. Generates the one-cycle frame
//             strobe, drives cs/mode/fixed_value and tracks the waveform
//             sample index. Host mode and fixed-value changes are shadowed
//             and only applied on frame boundaries.
//  Ports    : clk          - system clock
//             rst_l        - synchronous active-low reset
//             host         - host control bundle (slave side)
//             sync_300Hz   - one-cycle frame strobe to dac045a
//             mode         - applied mode to dac045a
//             fixed_value  - applied fixed value to dac045a (16 bits)
//             cs           - dac045a enable
//             sample_index - current waveform sample (valid in mode 1)
//             active       - scheduler is in ARM, RUN or DRAIN
//  Revision : 1.0  initial release
// ============================================================================
module dac_frame_scheduler
  import dac_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = DAC_CLK_DIV_300HZ,
  parameter int ARM_CYCLES = DAC_ARM_CYCLES,
  parameter int N_SAMPLES  = DAC_N_SAMPLES,
  parameter int SAMPLE_W   = 8
) (
  input  logic                clk,
  input  logic                rst_l,
  dac_frame_scheduler_if.slave host,
  output logic                sync_300Hz,
  output logic                mode,
  output logic [15:0]         fixed_value,
  output logic                cs,
  output logic [SAMPLE_W-1:0] sample_index,
  output logic                active
);

  // Arm counter is one bit wider than strictly needed so that ARM_CYCLES=1
  // still yields a legal width.
  localparam int ARM_W = $clog2(ARM_CYCLES + 1);
  localparam logic [ARM_W-1:0]    c_arm_last    = ARM_W'(ARM_CYCLES - 1);
  localparam logic [ARM_W-1:0]    c_arm_one     = ARM_W'(1);
  localparam logic [SAMPLE_W-1:0] c_sample_last = SAMPLE_W'(N_SAMPLES - 1);
  localparam logic [SAMPLE_W-1:0] c_sample_one  = SAMPLE_W'(1);

  dac_state_e          r_state;
  dac_state_e          w_state_nxt;
  logic [ARM_W-1:0]    r_arm_cnt;
  logic                r_mode;
  logic [15:0]         r_fixed_value;
  logic [15:0]         r_shadow;
  logic                r_pending;
  logic [SAMPLE_W-1:0] r_sample_index;
  logic [SAMPLE_W-1:0] w_sample_inc;

  logic w_tick;
  logic w_wrap;
  logic w_div_clear;
  logic w_div_run;
  logic w_apply;     // next cycle is a sync cycle: frame-boundary update edge
  logic w_to_idle;
  logic w_accept;

  // --------------------------------------------------------------------------
  // Frame divider: held at 0 in IDLE/ARM so the first RUN cycle sits at
  // phase 0; keeps counting through DRAIN so a resume preserves phase.
  // --------------------------------------------------------------------------
  assign w_div_clear = (r_state == ST_IDLE) || (r_state == ST_ARM);
  assign w_div_run   = (r_state == ST_RUN)  || (r_state == ST_DRAIN);

  dac_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .rst_l (rst_l),
    .clear (w_div_clear),
    .run   (w_div_run),
    .tick  (w_tick),
    .wrap  (w_wrap)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // w_apply is a look-ahead of the sync strobe: it is high exactly when the
  // next cycle will be RUN with the divider at 0, so the configuration
  // registers update on the same edge that raises sync_300Hz.
  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (host.enable) begin
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!host.enable) begin
          w_state_nxt = ST_IDLE;
        end else if (r_arm_cnt == c_arm_last) begin
          w_state_nxt = ST_RUN;
          w_apply     = 1'b1;
        end
      end
      // RUN and DRAIN share the same transitions; they differ only in
      // whether the divider landing on 0 produces a sync (RUN) or not.
      ST_RUN, ST_DRAIN: begin
        if (w_wrap) begin
          if (host.enable) begin
            w_state_nxt = ST_RUN;
            w_apply     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = host.enable ? ST_RUN : ST_DRAIN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_to_idle = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

  // Arm counter runs only while in ARM; any other state parks it at 0.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_arm_cnt <= '0;
    end else if (r_state == ST_ARM) begin
      r_arm_cnt <= r_arm_cnt + c_arm_one;
    end else begin
      r_arm_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Fixed-value shadow. fv_ready is simply !pending, so an accept and a
  // frame-boundary clear of pending can never coincide.
  // --------------------------------------------------------------------------
  assign w_accept = host.fv_valid && !r_pending;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_pending <= 1'b0;
      r_shadow  <= '0;
    end else if (w_accept) begin
      r_pending <= 1'b1;
      r_shadow  <= host.fv_data;
    end else if (w_apply) begin
      r_pending <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Frame-boundary apply of mode / fixed value and sample index tracking.
  // The index only advances when both the old and new mode are waveform;
  // entering waveform mode restarts the waveform at sample 0.
  // --------------------------------------------------------------------------
  assign w_sample_inc = (r_sample_index == c_sample_last) ? '0
                                                          : (r_sample_index + c_sample_one);

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_mode         <= DAC_MODE_FIXED;
      r_fixed_value  <= '0;
      r_sample_index <= '0;
    end else if (w_apply) begin
      r_mode <= host.mode_req;
      if (r_pending) begin
        r_fixed_value <= r_shadow;
      end
      if ((host.mode_req == DAC_MODE_WAVE) && (r_mode == DAC_MODE_WAVE)) begin
        r_sample_index <= w_sample_inc;
      end else begin
        r_sample_index <= '0;
      end
    end else if (w_to_idle) begin
      r_sample_index <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all decoded from registers)
  // --------------------------------------------------------------------------
  assign host.fv_ready = !r_pending;
  assign sync_300Hz    = (r_state == ST_RUN) && w_tick;
  assign mode          = r_mode;
  assign fixed_value   = r_fixed_value;
  assign sample_index  = r_sample_index;
  assign active        = (r_state != ST_IDLE);
  assign cs            = (r_state != ST_IDLE);

endmodule : dac_frame_scheduler
`default_nettype wire

// File: tb/tb_dac_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_frame_scheduler
//  Purpose  : Directed self-checking bench for dac_frame_scheduler. A small
//             instance (CLK_DIV=10, ARM_CYCLES=4, N_SAMPLES=4, SAMPLE_W=2)
//             covers sequencing, handshake, mode and reset behaviour; a
//             default-parameter instance covers the real frame spacing.
//             Inputs are driven and outputs sampled on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dac_frame_scheduler;

  logic clk = 1'b0;
  logic rst_l;

  always #5 clk = ~clk;

  dac_frame_scheduler_if bus_s ();
  dac_frame_scheduler_if bus_d ();

  logic        s_sync, s_mode, s_cs, s_active;
  logic [15:0] s_fv;
  logic [1:0]  s_idx;
  logic        d_sync, d_mode, d_cs, d_active;
  logic [15:0] d_fv;
  logic [7:0]  d_idx;

  dac_frame_scheduler #(
    .CLK_DIV    (10),
    .ARM_CYCLES (4),
    .N_SAMPLES  (4),
    .SAMPLE_W   (2)
  ) u_small (
    .clk          (clk),
    .rst_l        (rst_l),
    .host         (bus_s.slave),
    .sync_300Hz   (s_sync),
    .mode         (s_mode),
    .fixed_value  (s_fv),
    .cs           (s_cs),
    .sample_index (s_idx),
    .active       (s_active)
  );

  dac_frame_scheduler u_dflt (
    .clk          (clk),
    .rst_l        (rst_l),
    .host         (bus_d.slave),
    .sync_300Hz   (d_sync),
    .mode         (d_mode),
    .fixed_value  (d_fv),
    .cs           (d_cs),
    .sample_index (d_idx),
    .active       (d_active)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int nsync;

    rst_l          = 1'b0;
    bus_s.enable   = 1'b0;
    bus_s.mode_req = 1'b0;
    bus_s.fv_valid = 1'b0;
    bus_s.fv_data  = 16'h0000;
    bus_d.enable   = 1'b0;
    bus_d.mode_req = 1'b0;
    bus_d.fv_valid = 1'b0;
    bus_d.fv_data  = 16'h0000;

    // ---------------- reset state ----------------
    step(2);
    check("rst_cs",     s_cs,     0);
    check("rst_sync",   s_sync,   0);
    check("rst_mode",   s_mode,   0);
    check("rst_fv",     s_fv,     0);
    check("rst_ready",  bus_s.fv_ready, 1);
    check("rst_active", s_active, 0);
    check("rst_idx",    s_idx,    0);
    rst_l = 1'b1;
    step(1);
    check("idle_cs", s_cs, 0);

    // ---------------- startup ----------------
    bus_s.enable = 1'b1;
    step(1);
    check("arm_cs",     s_cs,     1);
    check("arm_active", s_active, 1);
    check("arm_sync",   s_sync,   0);
    step(3);
    check("arm_last_sync", s_sync, 0);
    step(1);
    check("first_sync", s_sync, 1);
    step(1);
    check("sync_width", s_sync, 0);
    cyc = 1;
    while (!s_sync && cyc < 100) begin
      step(1);
      cyc++;
    end
    check("sync_spacing", cyc, 10);

    // ---------------- fixed value handshake ----------------
    step(1);                              // divider 1
    check("fv_ready_free", bus_s.fv_ready, 1);
    bus_s.fv_valid = 1'b1;
    bus_s.fv_data  = 16'h7D00;
    step(1);                              // divider 2, accepted
    check("fv_ready_pend", bus_s.fv_ready, 0);
    check("fv_not_yet",    s_fv, 16'h0000);
    bus_s.fv_data = 16'hFFFF;             // second offer stalls
    step(8);                              // divider 0
    check("fv_apply_sync", s_sync, 1);
    check("fv_apply_val",  s_fv, 16'h7D00);
    check("fv_ready_back", bus_s.fv_ready, 1);
    step(1);                              // 0xFFFF accepted now
    check("fv2_pend", bus_s.fv_ready, 0);
    check("fv2_hold", s_fv, 16'h7D00);
    bus_s.fv_valid = 1'b0;
    step(9);
    check("fv2_sync",  s_sync, 1);
    check("fv2_apply", s_fv, 16'hFFFF);

    // ---------------- mode switch / sample index ----------------
    step(2);
    bus_s.mode_req = 1'b1;
    step(1);
    check("mode_hold", s_mode, 0);
    step(7);
    check("mode_apply", s_mode, 1);
    check("idx_enter",  s_idx,  0);
    for (int i = 1; i <= 5; i++) begin
      step(10);
      check("idx_sync", s_sync, 1);
      check("idx_seq",  s_idx,  i % 4);
    end
    step(3);
    bus_s.mode_req = 1'b0;
    step(7);
    check("mode_back", s_mode, 0);
    check("idx_clear", s_idx,  0);

    // ---------------- stop via DRAIN ----------------
    bus_s.mode_req = 1'b1;
    step(10);
    check("stop_idx0", s_idx, 0);
    step(10);
    check("stop_idx1", s_idx, 1);
    step(3);                              // divider 3
    bus_s.enable = 1'b0;
    step(1);                              // DRAIN, divider 4
    check("drain_cs", s_cs, 1);
    step(5);                              // divider 9
    check("drain_cs_last",   s_cs,   1);
    check("drain_sync_last", s_sync, 0);
    step(1);
    check("stop_cs",     s_cs,     0);
    check("stop_active", s_active, 0);
    check("stop_sync",   s_sync,   0);
    check("stop_idx",    s_idx,    0);
    nsync = 0;
    repeat (12) begin
      step(1);
      if (s_sync) nsync++;
    end
    check("stop_no_sync", nsync, 0);

    // ---------------- ARM abort ----------------
    bus_s.enable = 1'b1;
    step(1);
    check("abort_arm_cs", s_cs, 1);
    bus_s.enable = 1'b0;
    step(1);
    check("abort_cs", s_cs, 0);
    nsync = 0;
    repeat (8) begin
      step(1);
      if (s_sync) nsync++;
    end
    check("abort_no_sync", nsync, 0);

    // ---------------- value accepted in IDLE ----------------
    bus_s.mode_req = 1'b0;
    bus_s.fv_valid = 1'b1;
    bus_s.fv_data  = 16'h1234;
    check("idle_ready", bus_s.fv_ready, 1);
    step(1);
    bus_s.fv_valid = 1'b0;
    check("idle_pend",  bus_s.fv_ready, 0);
    check("idle_fv",    s_fv, 16'hFFFF);
    bus_s.enable = 1'b1;
    step(5);
    check("idle_first_sync", s_sync, 1);
    check("idle_apply",      s_fv, 16'h1234);
    check("idle_ready_back", bus_s.fv_ready, 1);

    // ---------------- DRAIN resume keeps phase ----------------
    step(2);                              // divider 2
    bus_s.enable = 1'b0;
    step(1);                              // DRAIN, divider 3
    check("resume_drain_cs", s_cs, 1);
    step(2);                              // divider 5
    bus_s.enable = 1'b1;
    step(4);                              // RUN, divider 9
    check("resume_pre_sync", s_sync, 0);
    step(1);
    check("resume_sync", s_sync, 1);

    // ---------------- reset mid-RUN ----------------
    bus_s.mode_req = 1'b1;
    step(10);
    check("pre_rst_mode", s_mode, 1);
    bus_s.fv_valid = 1'b1;
    bus_s.fv_data  = 16'h5555;
    step(1);
    bus_s.fv_valid = 1'b0;
    check("pre_rst_pend", bus_s.fv_ready, 0);
    step(2);
    rst_l          = 1'b0;
    bus_s.mode_req = 1'b0;
    step(1);
    check("mrst_cs",     s_cs,     0);
    check("mrst_sync",   s_sync,   0);
    check("mrst_mode",   s_mode,   0);
    check("mrst_fv",     s_fv,     0);
    check("mrst_ready",  bus_s.fv_ready, 1);
    check("mrst_active", s_active, 0);
    rst_l = 1'b1;
    step(5);
    check("mrst_first_sync", s_sync, 1);
    check("mrst_discard",    s_fv,   0);

    // ---------------- default parameters ----------------
    bus_d.enable = 1'b1;
    step(17);
    check("dflt_first_sync", d_sync, 1);
    check("dflt_fv0",        d_fv,   0);
    bus_d.fv_valid = 1'b1;
    bus_d.fv_data  = 16'hFFFF;
    step(1);
    bus_d.fv_valid = 1'b0;
    check("dflt_pend",     bus_d.fv_ready, 0);
    check("dflt_not_yet",  d_fv, 0);
    cyc = 1;
    while (!d_sync && cyc < 40000) begin
      step(1);
      cyc++;
    end
    check("dflt_spacing", cyc, 39683);
    check("dflt_apply",   d_fv, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dac_frame_scheduler
`default_nettype wire

// File: doc/dac_frame_scheduler.md
Name: dac_frame_scheduler

Overview:
- Sequences the dac045a core: generates the periodic sync_300Hz frame strobe and drives the core's cs, mode and fixed_value inputs.
- Host configuration changes (mode, fixed value) are shadowed and applied only on frame boundaries, so the core never sees a mid-frame update.
- Tracks the waveform sample index in mode 1.
- Sits between the host/register interface and dac045a, in the same clk domain.

Parameters:
- CLK_DIV, 39683, clk cycles per frame (11.905 MHz / 300 Hz); must be >= 2.
- ARM_CYCLES, 16, cycles cs is held high before the first sync pulse; must be >= 1.
- N_SAMPLES, 256, waveform length in samples for mode 1.
- SAMPLE_W, 8, width of sample_index; N_SAMPLES <= 2**SAMPLE_W.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  reset, synchronous, active-low.
- enable  in  1  level; 1 = run frames, 0 = stop at the next frame boundary.
- mode_req  in  1  requested dac045a mode (0 = fixed value, 1 = waveform).
- fv_valid  in  1  new fixed value offered.
- fv_data  in  16  fixed value payload.
- fv_ready  out  1  shadow register free; a transfer occurs when fv_valid & fv_ready.
- sync_300Hz  out  1  one-cycle frame strobe to dac045a.
- mode  out  1  applied mode to dac045a.
- fixed_value  out  16  applied fixed value to dac045a.
- cs  out  1  dac045a enable.
- sample_index  out  SAMPLE_W  current waveform sample, valid in mode 1.
- active  out  1  high in ARM, RUN and DRAIN.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low (rst_l).
- Reset values: sync_300Hz=0, mode=0, fixed_value=0, cs=0, sample_index=0, fv_ready=1, active=0, state=IDLE, pending flag cleared, divider=0.
- Reset asserted mid-operation: all of the above take effect on the same edge; any pending value is discarded; no sync is emitted in that cycle.
- FSM states: IDLE, ARM, RUN, DRAIN.
- IDLE:
  - cs=0; divider held at 0.
  - enable=1 moves to ARM on the next edge.
- ARM:
  - cs=1; arm counter runs 0..ARM_CYCLES-1.
  - enable=0 during ARM returns to IDLE; cs drops and no sync is emitted.
  - When the counter reaches ARM_CYCLES-1, move to RUN.
- RUN:
  - The first RUN cycle emits sync_300Hz=1 with divider=0.
  - The divider counts 0..CLK_DIV-1 and wraps; sync_300Hz=1 exactly when divider==0.
  - Sync pulses are therefore exactly CLK_DIV cycles apart, each one cycle wide.
- DRAIN:
  - Entered from RUN when enable=0.
  - cs stays 1 and the divider keeps counting.
  - In the cycle the divider would wrap to 0: no sync is emitted, cs=0, state goes to IDLE.
  - enable=1 again while in DRAIN returns to RUN with the divider phase preserved.
- Frame-boundary apply: on every sync cycle, registered on the same edge that raises sync_300Hz:
  - mode <= mode_req, sampled on that edge.
  - If pending: fixed_value <= shadow, pending cleared.
- Fixed-value handshake:
  - fv_ready = !pending, in every state.
  - On accept, store fv_data in the shadow and set pending.
  - A value accepted in a sync cycle is not applied at that sync; it is applied at the next one.
  - While pending, later offers stall (fv_ready=0) and the master holds its data.
  - Values accepted in IDLE are applied at the first RUN sync.
- sample_index, updated only on sync cycles:
  - New mode = 0: sample_index <= 0.
  - New mode = 1 with previous mode = 0: sample_index <= 0.
  - New mode = 1 with previous mode = 1: sample_index <= sample_index+1, wrapping from N_SAMPLES-1 to 0.
  - On the transition to IDLE: sample_index <= 0.
- active = (state != IDLE).

Decomposition:
- Package dac_ctrl_pkg:
  - FSM state enum (IDLE/ARM/RUN/DRAIN).
  - Default constants: DAC_CLK_DIV_300HZ=39683, DAC_ARM_CYCLES=16, DAC_N_SAMPLES=256.
  - Mode encodings: DAC_MODE_FIXED=0, DAC_MODE_WAVE=1.
- Sub-module dac_tick_div: parameterised CLK_DIV counter.
  - Inputs: clear, run.
  - Outputs: tick at count 0, wrap flag at count CLK_DIV-1.
  - Reused for other periodic strobes.

Test Plan (CLK_DIV=10, ARM_CYCLES=4, N_SAMPLES=4, SAMPLE_W=2 unless noted):
- Reset mid-RUN: rst_l low for 1 cycle -> next edge cs=0, sync=0, mode=0, fixed_value=0, fv_ready=1, active=0; pending shadow discarded.
- Startup: enable 0->1 at cycle 0 -> ARM during cycles 1-4; first sync at cycle 5, then cycles 15, 25, ...; cs=1 from cycle 1 onward; every sync is exactly 1 cycle wide.
- Fixed value: enable=1, offer 32000 (0x7D00) mid-frame -> accepted, fv_ready=0 until the next sync; fixed_value=0x7D00 from that sync edge; second offer 0xFFFF stalls until then.
- Mode switch: mode_req 0->1 mid-frame -> mode stays 0 until the next sync; sample_index across successive syncs = 0,1,2,3,0,1; mode_req back to 0 -> sample_index=0 at the next sync.
- Stop: enable 1->0 at divider=3 -> DRAIN; cs stays 1 until divider would wrap (6 more cycles); no further sync; state IDLE, active=0, sample_index=0.
- Default params: enable for 2 frames -> measured sync spacing is 39683 clk cycles; offer fv_data=0xFFFF in the same cycle as a sync -> value applied only at the following sync.
